// File: rtl/fp_add.sv
// fp_add: 2-stage pipelined IEEE-754 binary32 adder, round-to-nearest-even, 2-cycle latency.
// Define FP_ADD_DENORM_EN for subnormal support; otherwise inputs/results below 2^-126 flush to zero.
module fp_add (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result
);
`ifdef FP_ADD_DENORM_EN
   localparam bit DEN = 1'b1;
`else
   localparam bit DEN = 1'b0;
`endif
   logic        v0_q, v0_d, v1_q, v1_d, out_valid_q, out_valid_d;
   logic [31:0] a_q, a_d, b_q, b_d, spec_val_q, spec_val_d, result_q, result_d;
   logic        spec_q, spec_d, sign_q, sign_d, zsign_q, zsign_d;
   logic [7:0]  exp_q, exp_d;
   logic [27:0] sum_q, sum_d;
   logic        a_nan, b_nan, a_inf, b_inf, a_hid, b_hid, swap;
   logic [7:0]  ea, eb, el, es, d;
   logic [23:0] sa, sb, sig_l, sig_s;
   logic [49:0] ext;
   logic [26:0] al;
   logic [4:0]  lz;
   logic [9:0]  lim, sh, e_n, e_r;
   logic [26:0] norm;
   logic [24:0] rnd;
   logic [23:0] man;
   logic        inc;
   always_comb begin
      v0_d = in_valid;
      a_d = a;
      b_d = b;
      a_nan = &a_q[30:23] & |a_q[22:0];
      b_nan = &b_q[30:23] & |b_q[22:0];
      a_inf = &a_q[30:23] & ~|a_q[22:0];
      b_inf = &b_q[30:23] & ~|b_q[22:0];
      a_hid = |a_q[30:23];
      b_hid = |b_q[30:23];
      // subnormals live at effective exponent 1; in flush mode exponent-0 inputs become zero
      ea = (DEN && !a_hid) ? 8'd1 : a_q[30:23];
      eb = (DEN && !b_hid) ? 8'd1 : b_q[30:23];
      sa = (DEN || a_hid) ? {a_hid, a_q[22:0]} : 24'd0;
      sb = (DEN || b_hid) ? {b_hid, b_q[22:0]} : 24'd0;
      swap = {eb, sb} > {ea, sa};
      el = swap ? eb : ea;
      es = swap ? ea : eb;
      sig_l = swap ? sb : sa;
      sig_s = swap ? sa : sb;
      d = el - es;
      ext = {sig_s, 26'd0} >> d;
      al = (d >= 8'd26) ? {26'd0, |sig_s} : {ext[49:24], ext[23] | |ext[22:0]};
      sum_d = (a_q[31] ^ b_q[31]) ? {1'b0, sig_l, 3'd0} - {1'b0, al} : {1'b0, sig_l, 3'd0} + {1'b0, al};
      v1_d = v0_q;
      exp_d = el;
      sign_d = swap ? b_q[31] : a_q[31];
      zsign_d = a_q[31] & b_q[31];
      spec_d = a_nan | b_nan | a_inf | b_inf;
      spec_val_d = (a_nan | b_nan | (a_inf & b_inf & (a_q[31] ^ b_q[31]))) ? 32'h7fc00000
                 : a_inf ? {a_q[31], 8'hff, 23'd0} : {b_q[31], 8'hff, 23'd0};
   end
   always_comb begin
      lz = 5'd27;
      for (int i = 0; i < 27; i++) if (sum_q[i]) lz = 5'(26 - i);
      // with subnormals, stop the left shift at exponent 1 so the result denormalizes
      lim = {2'b0, exp_q} - 10'd1;
      sh = (DEN && lim < 10'(lz)) ? lim : 10'(lz);
      norm = sum_q[27] ? {sum_q[27:2], |sum_q[1:0]} : sum_q[26:0] << sh;
      e_n = sum_q[27] ? {2'b0, exp_q} + 10'd1 : {2'b0, exp_q} - sh;
      inc = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd = {1'b0, norm[26:3]} + {24'd0, inc};
      man = rnd[24] ? rnd[24:1] : rnd[23:0];
      e_r = e_n + {9'd0, rnd[24]};
      out_valid_d = v1_q;
      result_d = !v1_q ? result_q
               : spec_q ? spec_val_q
               : ~|sum_q ? {zsign_q, 31'd0}
               : ($signed(e_r) > 10'sd254) ? {sign_q, 8'hff, 23'd0}
               : DEN ? {sign_q, man[23] ? e_r[7:0] : 8'd0, man[22:0]}
               : ($signed(e_r) < 10'sd1) ? {sign_q, 31'd0}
               : {sign_q, e_r[7:0], man[22:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q <= 1'b0;
         v1_q <= 1'b0;
         out_valid_q <= 1'b0;
         result_q <= 32'd0;
      end else begin
         v0_q <= v0_d;
         v1_q <= v1_d;
         out_valid_q <= out_valid_d;
         result_q <= result_d;
      end
      a_q <= a_d;
      b_q <= b_d;
      exp_q <= exp_d;
      sum_q <= sum_d;
      sign_q <= sign_d;
      zsign_q <= zsign_d;
      spec_q <= spec_d;
      spec_val_q <= spec_val_d;
   end
   assign out_valid = out_valid_q;
   assign result = result_q;
endmodule

// File: tb/tb_fp_add.sv
// tb_fp_add: self-checking bench for fp_add against an exact-integer binary32 addition model.
// Honors FP_ADD_DENORM_EN the same way as the design.
module tb_fp_add;
`ifdef FP_ADD_DENORM_EN
   localparam bit DEN = 1'b1;
`else
   localparam bit DEN = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        out_valid;
   logic [31:0] result;
   int          checks = 0, errors = 0;
   logic        s0_v = 1'b0, s1_v = 1'b0, exp_v = 1'b0;
   logic [31:0] s0_r = 32'd0, s1_r = 32'd0, exp_r = 32'd0;
   fp_add dut (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .out_valid(out_valid), .result(result));
   always #5 clk = ~clk;
   // values are integers in units of 2^-149, summed exactly, then rounded once
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic [299:0] mx, my, s, q, rem, half;
      logic         sg;
      int           p, sh, e;
      if ((&x[30:23] && |x[22:0]) || (&y[30:23] && |y[22:0])) return 32'h7fc00000;
      if (&x[30:23] && &y[30:23] && x[31] != y[31]) return 32'h7fc00000;
      if (&x[30:23]) return x;
      if (&y[30:23]) return y;
      mx = (x[30:23] == 8'd0) ? (DEN ? 300'(x[22:0]) : 300'd0) : 300'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
      my = (y[30:23] == 8'd0) ? (DEN ? 300'(y[22:0]) : 300'd0) : 300'({1'b1, y[22:0]}) << (y[30:23] - 8'd1);
      if (x[31] == y[31]) begin s = mx + my; sg = x[31]; end
      else if (mx >= my) begin s = mx - my; sg = x[31]; end
      else begin s = my - mx; sg = y[31]; end
      if (s == 300'd0) return {x[31] & y[31], 31'd0};
      p = 0;
      for (int i = 0; i < 300; i++) if (s[i]) p = i;
      if (p < 23) return DEN ? {sg, 8'd0, s[22:0]} : {sg, 31'd0};
      sh = p - 23;
      q = s >> sh;
      rem = s - (q << sh);
      half = (sh > 0) ? (300'd1 << (sh - 1)) : 300'd0;
      if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + 300'd1;
      e = p - 22;
      if (q[24]) begin q = q >> 1; e++; end
      if (e >= 255) return {sg, 8'hff, 23'd0};
      return {sg, 8'(e), q[22:0]};
   endfunction
   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: return {r[31], 8'hff, r[0] ? r[22:0] : 23'd0};
         1: return {r[31], 8'h00, r[1] ? r[22:0] : 23'd0};
         2: return {r[31], 5'b10000, r[25:0]};
         3: return {r[31], 5'b01111, r[25:0]};
         4: return {r[31], 8'hfe, r[22:0]};
         5: return {r[31], 5'b00000, r[25:0]};
         default: return r;
      endcase
   endfunction
   // one clock: drive inputs, advance the expected 2-deep pipeline, sample #1 after the edge
   task automatic step(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y);
      rst = r; in_valid = v; a = x; b = y;
      @(posedge clk); #1;
      if (r) begin
         s0_v = 1'b0; s1_v = 1'b0; exp_v = 1'b0; exp_r = 32'd0;
      end else begin
         exp_v = s1_v;
         if (s1_v) exp_r = s1_r;
         s1_v = s0_v; s1_r = s0_r;
         s0_v = v; s0_r = ref_add(x, y);
      end
   endtask
   task automatic test_reset();
      step(1'b1, 1'b1, 32'h40400000, 32'h40400000);
      step(1'b1, 1'b1, 32'h40400000, 32'h40400000);
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd0) begin
         errors++; $display("FAIL reset_state: out_valid=%0b result=%08h, want 0 00000000", out_valid, result);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL reset_ignores_in_valid[%0d]: out_valid=%0b result=%08h, want 0 00000000", i, out_valid, result);
         end
      end
   endtask
   logic [31:0] va [12] = '{32'h40400000, 32'h00000000, 32'h7f800000, 32'hc0400000, 32'h7fc00000, 32'h40200000,
                            32'h7f800000, 32'h3f800000, 32'h3f800001, 32'h40400000, 32'h7f7fffff, 32'h80000000};
   logic [31:0] vb [12] = '{32'h40400000, 32'h40400000, 32'h40400000, 32'hc0400000, 32'h40400000, 32'h40500000,
                            32'hff800000, 32'h33800000, 32'h33800000, 32'hc0400000, 32'h7f7fffff, 32'h80000000};
   logic [31:0] vr [12] = '{32'h40c00000, 32'h40400000, 32'h7f800000, 32'hc0c00000, 32'h7fc00000, 32'h40b80000,
                            32'h7fc00000, 32'h3f800000, 32'h3f800002, 32'h00000000, 32'h7f800000, 32'h80000000};
   task automatic test_directed();
      for (int k = 0; k < 24; k++) begin
         step(1'b0, 1'b1, k[0] ? vb[k/2] : va[k/2], k[0] ? va[k/2] : vb[k/2]);
         step(1'b0, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early[%0d]: out_valid=%0b, want 0", k, out_valid);
         end
         step(1'b0, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b1 || result !== vr[k/2]) begin
            errors++; $display("FAIL directed[%0d]: out_valid=%0b result=%08h, want 1 %08h", k, out_valid, result, vr[k/2]);
         end
      end
      step(1'b0, 1'b0, 32'd0, 32'd0);
      checks++;
      if (out_valid !== 1'b0 || result !== vr[11]) begin
         errors++; $display("FAIL hold_idle: out_valid=%0b result=%08h, want 0 %08h", out_valid, result, vr[11]);
      end
   endtask
   task automatic test_back_to_back();
      logic [31:0] want;
      for (int k = 0; k < 9; k++) begin
         step(1'b0, k < 6, k < 6 ? va[k] : 32'd0, k < 6 ? vb[k] : 32'd0);
         want = (k < 2) ? vr[11] : (k < 8) ? vr[k-2] : vr[5];
         checks++;
         if (out_valid !== (k >= 2 && k < 8) || result !== want) begin
            errors++; $display("FAIL back_to_back[%0d]: out_valid=%0b result=%08h, want %0b %08h", k, out_valid, result, k >= 2 && k < 8, want);
         end
      end
   endtask
   task automatic test_reset_inflight();
      step(1'b0, 1'b1, 32'h40400000, 32'h40400000);
      step(1'b0, 1'b1, 32'h40200000, 32'h40500000);
      step(1'b1, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b0 || result !== 32'd0) begin
            errors++; $display("FAIL reset_inflight[%0d]: out_valid=%0b result=%08h, want 0 00000000", i, out_valid, result);
         end
      end
   endtask
   task automatic test_denorm();
      logic [31:0] x [3] = '{32'h00000001, 32'h80000001, 32'h00800000};
      logic [31:0] y [3] = '{32'h00000001, 32'h00000001, 32'h80000001};
      logic [31:0] w [3];
      w = '{DEN ? 32'h00000002 : 32'h0, 32'h00000000, DEN ? 32'h007fffff : 32'h00800000};
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, x[k], y[k]);
         step(1'b0, 1'b0, 32'd0, 32'd0);
         step(1'b0, 1'b0, 32'd0, 32'd0);
         checks++;
         if (out_valid !== 1'b1 || result !== w[k]) begin
            errors++; $display("FAIL denorm[%0d]: out_valid=%0b result=%08h, want 1 %08h", k, out_valid, result, w[k]);
         end
      end
   endtask
   task automatic test_random(input int n);
      logic [31:0] x, y, px, py;
      logic        v;
      px = 32'd0; py = 32'd0;
      for (int i = 0; i < n + 2; i++) begin
         v = (i < n) && ($urandom_range(0, 3) != 0);
         if (i % 2 == 1) begin x = py; y = px; end
         else begin x = rand_op(); y = rand_op(); end
         step(1'b0, v, x, y);
         px = x; py = y;
         checks++;
         if (out_valid !== exp_v || result !== exp_r) begin
            errors++; $display("FAIL random[%0d]: out_valid=%0b result=%08h, want %0b %08h", i, out_valid, result, exp_v, exp_r);
         end
      end
   endtask
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_inflight();
      test_denorm();
      test_random(600);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
